// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scan controller
//
// Purpose: FSM state type, keypad geometry constants and a row-drive helper
//          used by keypad_scan_ctrl.
package keypad_pkg;

  localparam int NUM_KEYS = 16;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int KEY_W    = 4;

  localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EVAL = 2'd2,
    EMIT = 2'd3
  } state_e;

  // Active-low one-hot drive for the selected row.
  function automatic logic [ROWS-1:0] row_drive(input logic [1:0] idx);
    return ~(ROWS'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// rtl/keypad_evt_fifo.sv - synchronous event FIFO with valid/ready ports
//
// Purpose: stores key events between the scan FSM and the consumer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_tdata/s_tvalid  write side; s_tready low means a push would be dropped
//   m_tdata/m_tvalid  head entry; held stable until m_tready accepts it
//   m_tready          consumer accept
module keypad_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign do_pop   = m_tvalid && m_tready;
  // When full the head is valid, so a same-cycle pop frees the slot being written.
  assign s_tready = !full || m_tready;
  assign do_push  = s_tvalid && s_tready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = s_tdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with debounce and event FIFO
//
// Purpose: drives one row low at a time, samples the columns into a frame
//          snapshot, accepts a frame after DEB_SCANS identical frames and
//          emits press/release events in ascending key order.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  scan enable
//   col[3:0]            active-low column inputs (asynchronous)
//   row[3:0]            active-low row drive, 4'b1111 when not scanning
//   key_state[15:0]     debounced pressed map, bit 4*row+col
//   ev_valid/ev_ready   event handshake
//   ev_code, ev_press   head event key index and press(1)/release(0)
//   overflow, clr_ovf   sticky dropped-event flag and its clear
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int DEB_SCANS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [COLS-1:0]     col,
  output logic [ROWS-1:0]     row,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [KEY_W-1:0]    ev_code,
  output logic                ev_press,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int             DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]     DEB_CNT  = 3'(DEB_SCANS);
  localparam int             EV_W     = KEY_W + 1;

  state_e              state_q, state_d;
  logic [COLS-1:0]     sync1_q, sync1_d;
  logic [COLS-1:0]     sync2_q, sync2_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [ROWS-1:0]     row_q, row_d;
  logic [NUM_KEYS-1:0] snapshot_q, snapshot_d;
  logic [NUM_KEYS-1:0] prev_snap_q, prev_snap_d;
  logic [2:0]          stable_cnt_q, stable_cnt_d;
  logic [NUM_KEYS-1:0] key_state_q, key_state_d;
  logic [KEY_W-1:0]    emit_idx_q, emit_idx_d;
  logic                overflow_q, overflow_d;

  logic [COLS-1:0]     col_pressed;
  logic [2:0]          cnt_next;
  logic                push;
  logic [EV_W-1:0]     push_data;
  logic                fifo_s_tready;
  logic [EV_W-1:0]     fifo_m_tdata;

  assign col_pressed = ~sync2_q;
  assign push_data   = {emit_idx_q, snapshot_q[emit_idx_q]};

  always_comb begin
    state_d      = state_q;
    sync1_d      = col;
    sync2_d      = sync1_q;
    div_d        = div_q;
    row_idx_d    = row_idx_q;
    snapshot_d   = snapshot_q;
    prev_snap_d  = prev_snap_q;
    stable_cnt_d = stable_cnt_q;
    key_state_d  = key_state_q;
    emit_idx_d   = emit_idx_q;
    push         = 1'b0;

    // Saturating count of identical consecutive frames.
    if (snapshot_q == prev_snap_q) begin
      cnt_next = (stable_cnt_q >= DEB_CNT) ? DEB_CNT : stable_cnt_q + 3'd1;
    end else begin
      cnt_next = 3'd1;
    end

    case (state_q)
      IDLE: begin
        div_d     = '0;
        row_idx_d = '0;
        if (en) state_d = SCAN;
      end
      SCAN: begin
        if (!en) begin
          state_d      = IDLE;
          div_d        = '0;
          row_idx_d    = '0;
          snapshot_d   = '0;
          stable_cnt_d = '0;
        end else if (div_q == DIV_LAST) begin
          div_d                                = '0;
          snapshot_d[{row_idx_q, 2'b00} +: COLS] = col_pressed;
          row_idx_d                            = row_idx_q + 2'd1;
          if (row_idx_q == 2'(ROWS - 1)) state_d = EVAL;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      EVAL: begin
        if (!en) begin
          state_d      = IDLE;
          row_idx_d    = '0;
          snapshot_d   = '0;
          stable_cnt_d = '0;
        end else begin
          stable_cnt_d = cnt_next;
          prev_snap_d  = snapshot_q;
          if (cnt_next >= DEB_CNT && snapshot_q != key_state_q) begin
            state_d    = EMIT;
            emit_idx_d = '0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      EMIT: begin
        push       = (snapshot_q[emit_idx_q] != key_state_q[emit_idx_q]);
        emit_idx_d = emit_idx_q + KEY_W'(1);
        if (emit_idx_q == KEY_W'(NUM_KEYS - 1)) begin
          key_state_d = snapshot_q;
          state_d     = en ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Row drive follows the next state so row and state change together.
    row_d = (state_d == SCAN) ? row_drive(row_idx_d) : ROW_IDLE;

    if (push && !fifo_s_tready) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      div_q        <= '0;
      row_idx_q    <= '0;
      row_q        <= ROW_IDLE;
      snapshot_q   <= '0;
      prev_snap_q  <= '0;
      stable_cnt_q <= '0;
      key_state_q  <= '0;
      emit_idx_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      div_q        <= div_d;
      row_idx_q    <= row_idx_d;
      row_q        <= row_d;
      snapshot_q   <= snapshot_d;
      prev_snap_q  <= prev_snap_d;
      stable_cnt_q <= stable_cnt_d;
      key_state_q  <= key_state_d;
      emit_idx_q   <= emit_idx_d;
      overflow_q   <= overflow_d;
    end
  end

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_evt_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (push_data),
    .s_tvalid (push),
    .s_tready (fifo_s_tready),
    .m_tdata  (fifo_m_tdata),
    .m_tvalid (ev_valid),
    .m_tready (ev_ready)
  );

  assign row       = row_q;
  assign key_state = key_state_q;
  assign ev_code   = fifo_m_tdata[EV_W-1:1];
  assign ev_press  = fifo_m_tdata[0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int DEB_SCANS  = 3;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_state;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  keypad_scan_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DEB_SCANS  (DEB_SCANS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .col       (col),
    .row       (row),
    .key_state (key_state),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_press  (ev_press),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column.
  logic [15:0] key_map = '0;
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (row[r] == 1'b0) col = col & ~key_map[4*r +: 4];
    end
  end

  typedef struct {
    logic [3:0] code;
    logic       press;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          ready_mode = 2;  // 0 hold low, 1 random, 2 always high

  // Frame-level reference: debounce counter over whole frames and the accepted map.
  logic [15:0] m_prev = '0;
  logic [15:0] m_acc = '0;
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void push_exp(input int code, input logic press);
    ev_t e;
    e.code  = 4'(code);
    e.press = press;
    if (ready_mode == 0 && exp_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  function automatic void model_step(input logic [15:0] m);
    if (m == m_prev) m_cnt = (m_cnt + 1 > DEB_SCANS) ? DEB_SCANS : m_cnt + 1;
    else m_cnt = 1;
    m_prev = m;
    if (m_cnt >= DEB_SCANS && m != m_acc) begin
      for (int i = 0; i < 16; i++) begin
        if (m[i] != m_acc[i]) push_exp(i, m[i]);
      end
      m_acc = m;
    end
  endfunction

  function automatic logic [15:0] rand_map();
    logic [15:0] m;
    int k;
    m = '0;
    k = $urandom_range(0, 2);
    for (int j = 0; j < k; j++) m[$urandom_range(0, 15)] = 1'b1;
    return m;
  endfunction

  // Returns at the negedge of the cycle after the last row (the evaluation cycle).
  task automatic wait_frame(output bit ok);
    int n;
    n = 0;
    while (row !== 4'b0111 && n < 200) begin @(negedge clk); n++; end
    while (row === 4'b0111 && n < 200) begin @(negedge clk); n++; end
    ok = (n < 200) && (row === 4'b1111);
  endtask

  task automatic frame(input logic [15:0] m);
    bit ok;
    key_map = m;
    wait_frame(ok);
    if (!ok) begin
      n_checks++;
      $display("FAIL frame_end: row=%b, frame did not complete within bound", row);
    end else begin
      chk("key_state_frame", 32'(key_state), 32'(m_acc));
    end
    model_step(m);
  endtask

  // Monitor: drives ev_ready and compares every accepted event with the scoreboard.
  bit         held = 0;
  logic [3:0] h_code;
  logic       h_press;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(ev_valid), 32'(1));
          chk("hold_code", 32'(ev_code), 32'(h_code));
          chk("hold_press", 32'(ev_press), 32'(h_press));
        end
        case (ready_mode)
          0:       ev_ready = 1'b0;
          1:       ev_ready = ($urandom_range(0, 3) != 0);
          default: ev_ready = 1'b1;
        endcase
        held = 0;
        if (ev_valid && ev_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL ev_unexpected: got code %0d press %0d, expected no event", ev_code, ev_press);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("ev_code", 32'(ev_code), 32'(e.code));
            chk("ev_press", 32'(ev_press), 32'(e.press));
          end
        end else if (ev_valid) begin
          held    = 1;
          h_code  = ev_code;
          h_press = ev_press;
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s: %0d events still pending, expected 0", name, exp_q.size());
    end
    @(negedge clk);
    chk({name, "_valid"}, 32'(ev_valid), 32'(0));
  endtask

  initial begin
    int n;
    logic [15:0] m;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_row", 32'(row), 32'h0000000F);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_ev_valid", 32'(ev_valid), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_ev_code", 32'({ev_code, ev_press}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_row", 32'(row), 32'h0000000F);

    // First frame: row sequence with no keys pressed
    key_map = '0;
    en = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        chk("scan_row", 32'(row), 32'(4'(~(4'b0001 << r))));
        @(negedge clk);
      end
    end
    chk("eval_row", 32'(row), 32'h0000000F);
    model_step(16'h0000);

    // Key 6 press then release
    repeat (4) frame(16'h0040);
    chk("key6_state", 32'(key_state), 32'h00000040);
    repeat (4) frame(16'h0000);
    chk("key6_released", 32'(key_state), 32'h0);

    // Key 6 in alternate frames only: never stable
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 16'h0040 : 16'h0000);
    frame(16'h0000);
    chk("alt_state", 32'(key_state), 32'h0);

    // Keys 3 and 12 together
    repeat (4) frame(16'h1008);
    chk("k3_12_state", 32'(key_state), 32'h00001008);

    // Overflow: five changes with the consumer stalled
    ready_mode = 0;
    repeat (4) frame(16'h001F);
    chk("ovf_set", 32'(overflow), 32'(m_ovf));
    chk("ovf_valid", 32'(ev_valid), 32'(1));
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'(0));

    // Disable in the middle of a scan
    n = 0;
    while (row !== 4'b1101 && n < 100) begin @(negedge clk); n++; end
    if (row !== 4'b1101) begin
      n_checks++;
      $display("FAIL en_off_wait: row=%b, expected 1101 within bound", row);
    end
    en = 1'b0;
    @(negedge clk);
    chk("en_off_row", 32'(row), 32'h0000000F);
    m_cnt = 0;
    repeat (5) @(negedge clk);
    chk("en_off_row_held", 32'(row), 32'h0000000F);
    chk("en_off_key_state", 32'(key_state), 32'(m_acc));
    chk("en_off_valid", 32'(ev_valid), 32'(1));
    chk("en_off_head", 32'({ev_code, ev_press}), 32'({exp_q[0].code, exp_q[0].press}));
    ready_mode = 2;
    wait_drain("ovf_drain");

    // Re-enable and release all
    key_map = '0;
    en = 1'b1;
    repeat (4) frame(16'h0000);
    chk("release_all", 32'(key_state), 32'h0);

    // Randomized frames with random consumer back-pressure
    ready_mode = 1;
    for (int g = 0; g < 25; g++) begin
      m = rand_map();
      n = $urandom_range(1, 4);
      for (int f = 0; f < n; f++) frame(m);
    end
    repeat (3) frame(m);
    wait_drain("rand_drain");
    chk("rand_overflow", 32'(overflow), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
